pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
// - Parametrised elastic pipeline stage register; replaces the fixed-field stage register between IF/ID/EX/MEM/WB.
// - Carries one flat WIDTH-bit payload with a valid/ready handshake, synchronous flush and in-place patching.
// - Patching writes bits of the held entry, e.g. to clear dREN/dWEN and capture dmemload while stalled.
// - A 2-entry skid buffer keeps in_ready registered and sustains 1 transfer/cycle without a combinational ready path.
// PARAMETERS
// - WIDTH      32            payload width in bits (>=1)
// - KILL_MASK  {WIDTH{1'b1}} payload bits forced to 0 on flush (control bits); other bits keep their value
// - RST_VAL    '0            payload value of both entries after reset
// - CNT_W      16            stall counter width (only with PIPE_STAGE_PERF_EN)
// PORTS
// - CLK         in   1      clock, rising edge
// - nRST        in   1      asynchronous reset, active-low
// - in_valid    in   1      upstream has a payload
// - in_ready    out  1      stage can accept; registered, equals !skid_valid
// - in_data     in   WIDTH  upstream payload
// - out_valid   out  1      main entry holds a payload
// - out_ready   in   1      downstream accepts
// - out_data    out  WIDTH  main entry payload, driven directly by a register
// - flush       in   1      synchronous kill of all held entries
// - patch_en    in   1      patch the main entry this cycle
// - patch_mask  in   WIDTH  bits of the main entry to overwrite
// - patch_data  in   WIDTH  replacement values for masked bits
// - stall_cnt   out  CNT_W  saturating stall-cycle count (PIPE_STAGE_PERF_EN only)
// BEHAVIOUR
// - Reset, async, nRST=0:
//   - main_valid=0, skid_valid=0, so out_valid=0 and in_ready=1.
//   - main_data=RST_VAL, skid_data=RST_VAL, stall_cnt=0.
//   - Reset mid-transfer drops both entries; no payload survives.
// - Handshakes:
//   - push = in_valid & in_ready; pop = out_valid & out_ready.
//   - in_data is sampled only on push; out_valid never drops without pop or flush.
//   - out_data is stable while out_valid & !out_ready, except for patch.
// - Occupancy states: EMPTY(0) -> ONE(1) -> FULL(2); only main holds in ONE, main+skid in FULL.
//   - EMPTY, push: ONE, and main <= in_data.
//   - ONE, push & pop: ONE, and main <= in_data.
//   - ONE, push & !pop: FULL, and skid <= in_data.
//   - ONE, pop & !push: EMPTY.
//   - FULL, pop: ONE, and main <= skid. in_ready=0 in FULL, so no push.
//   - In all other cases the state and data hold.
// - Latency: in_data appears on out_data 1 cycle after push into EMPTY, or into ONE with pop. Throughput 1/cycle.
// - flush has the highest priority (below reset) and overrides push, pop and patch:
//   - Next cycle: main_valid=0, skid_valid=0, main_data &= ~KILL_MASK, skid_data &= ~KILL_MASK.
//   - A push in the flush cycle is discarded, and in_ready=1 the next cycle.
// - patch_en & !flush:
//   - main_data <= (main_data & ~patch_mask) | (patch_data & patch_mask).
//   - Applies whether or not main_valid is set; skid is never patched.
//   - Patch and pop in the same cycle: the patch is applied first; the refill from skid or in_data wins on the register.
//   - Patch and no pop: the patched value is held until pop.
// PIPE_STAGE_PERF_EN
// - When defined: stall_cnt port exists.
//   - Increments when out_valid & !out_ready & !flush; saturates at 2^CNT_W-1.
//   - Does not clear on flush; clears only on reset.
// - When not defined: stall_cnt port and counter logic are absent; behaviour is otherwise identical.
// CONFIGURATION
// - WIDTH=1 is legal.
// - KILL_MASK='0 makes flush clear valids only.
// TESTING
// - Reset with in_valid=1, in_data=32'hA5A5_0001
//   -> out_valid=0, in_ready=1, out_data=RST_VAL during reset; out_data=32'hA5A5_0001 one cycle after release.
// - Stream 0,1,2..9 with out_ready held 1
//   -> out_data 0..9 on 10 consecutive cycles; in_ready never drops.
// - out_ready=0, push 32'h11 then 32'h22
//   -> in_ready=0 after the second push.
//   -> out_ready=1 yields 32'h11 then 32'h22 on consecutive cycles.
// - FULL, flush=1 with in_valid=1, KILL_MASK=32'hFF
//   -> next cycle out_valid=0, in_ready=1, main low byte=8'h00, high bits kept; the flushed push never appears.
// - Main=32'h0000_0003 stalled, patch_en=1, patch_mask=32'hFFFF_0003, patch_data=32'hBEEF_0000
//   -> out_data=32'hBEEF_0000, still valid, then popped once.
// - With PIPE_STAGE_PERF_EN, CNT_W=2, out_valid stalled 5 cycles
//   -> stall_cnt=0,1,2,3,3; without the macro the bench compiles with no stall_cnt port.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: main register plus one-entry skid, registered in_ready, flush and in-place patch.
// Optional macro PIPE_STAGE_PERF_EN adds the saturating stall_cnt output and its CNT_W parameter.
//
// state | meaning
// EMPTY | no payload held
// ONE   | main entry holds a payload
// FULL  | main and skid both hold payloads, in_ready low
module pipe_stage_skid #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] KILL_MASK = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RST_VAL   = '0
`ifdef PIPE_STAGE_PERF_EN
  , parameter int             CNT_W     = 16
`endif
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  input  logic             patch_en,
  input  logic [WIDTH-1:0] patch_mask,
  input  logic [WIDTH-1:0] patch_data
`ifdef PIPE_STAGE_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;

  occ_t             state, state_nxt;
  logic [WIDTH-1:0] main_data, skid_data, main_nxt, patched;
  logic             push, pop;
  logic             ld_main_in, ld_main_skid, ld_skid;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)      state <= EMPTY;
    else if (flush) state <= EMPTY;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = FULL;
        else if (pop && !push) state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // in_ready and out_valid decode only flop outputs, so no input-to-ready path exists
  always_comb begin
    out_valid    = (state != EMPTY);
    in_ready     = (state != FULL);
    ld_main_in   = push && ((state == EMPTY) || ((state == ONE) && pop));
    ld_main_skid = (state == FULL) && pop;
    ld_skid      = (state == ONE) && push && !pop;
  end

  // A refill on pop overrides any patch of the departing entry
  always_comb begin
    patched  = patch_en ? ((main_data & ~patch_mask) | (patch_data & patch_mask)) : main_data;
    main_nxt = patched;
    if (ld_main_in)        main_nxt = in_data;
    else if (ld_main_skid) main_nxt = skid_data;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      main_data <= RST_VAL;
      skid_data <= RST_VAL;
    end else if (flush) begin
      main_data <= main_data & ~KILL_MASK;
      skid_data <= skid_data & ~KILL_MASK;
    end else begin
      main_data <= main_nxt;
      if (ld_skid) skid_data <= in_data;
    end
  end

  assign out_data = main_data;

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && !flush && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed cases plus random traffic against a queue model.
// Define PIPE_STAGE_PERF_EN to also check stall_cnt with CNT_W=2.
module tb_pipe_stage_skid;
  localparam int          W  = 32;
  localparam logic [31:0] KM = 32'h0000_00FF;
  localparam logic [31:0] RV = 32'hDEAD_0000;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0, patch_en = 1'b0;
  logic [W-1:0]  in_data = '0, patch_mask = '0, patch_data = '0;
  logic          in_ready, out_valid;
  logic [W-1:0]  out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [1:0]    stall_cnt;
`endif

  pipe_stage_skid #(
    .WIDTH(W), .KILL_MASK(KM), .RST_VAL(RV)
`ifdef PIPE_STAGE_PERF_EN
    , .CNT_W(2)
`endif
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .patch_en(patch_en), .patch_mask(patch_mask), .patch_data(patch_data)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] q[$];
  logic [31:0] hd;
  int unsigned m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    hd    = RV;
    m_cnt = 0;
  endtask

  // Stage seen as a FIFO of depth 2 whose head is what out_data shows
  task automatic model_step();
    bit do_push, do_pop;
    do_push = in_valid && (q.size() < 2);
    do_pop  = out_ready && (q.size() > 0);
    if ((q.size() > 0) && !out_ready && !flush && (m_cnt < 3)) m_cnt++;
    if (flush) begin
      q.delete();
      hd = hd & ~KM;
    end else begin
      if (patch_en) begin
        hd = (hd & ~patch_mask) | (patch_data & patch_mask);
        if (q.size() > 0) q[0] = hd;
      end
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(in_data);
      if (q.size() > 0) hd = q[0];
    end
  endtask

  task automatic check_model();
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
    chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
    chk("out_data", out_data, hd);
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt", {30'b0, stall_cnt}, m_cnt);
`endif
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_step();
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; flush = 1'b0; patch_en = 1'b0; out_ready = 1'b1;
    repeat (n) cycle();
  endtask

`ifdef PIPE_STAGE_PERF_EN
  int exp_sc[4] = '{1, 2, 3, 3};
`endif

  initial begin
    // reset while upstream is offering a payload
    model_reset();
    in_valid = 1'b1; in_data = 32'hA5A5_0001; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_data", out_data, RV);
    nRST = 1'b1;
    cycle();
    chk("rst_release_data", out_data, 32'hA5A5_0001);
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_seq0", {30'b0, stall_cnt}, 32'd0);
`endif
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
`ifdef PIPE_STAGE_PERF_EN
      chk("stall_seq", {30'b0, stall_cnt}, exp_sc[i]);
`endif
    end
    idle(2);

    // back-to-back stream
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = i;
      cycle();
      chk("stream_data", out_data, i);
      chk("stream_ready", {31'b0, in_ready}, 32'd1);
    end
    idle(2);

    // fill skid while stalled, then drain
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
    cycle();
    in_data = 32'h22;
    cycle();
    chk("skid_in_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    chk("skid_first", out_data, 32'h11);
    cycle();
    chk("skid_second", out_data, 32'h22);
    cycle();
    chk("skid_drained", {31'b0, out_valid}, 32'd0);
    idle(1);

    // flush from FULL with a competing push
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1234_5678;
    cycle();
    in_data = 32'h9ABC_DEF0;
    cycle();
    flush = 1'b1; in_data = 32'h0000_0077;
    cycle();
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_ready", {31'b0, in_ready}, 32'd1);
    chk("flush_data", out_data, 32'h1234_5600);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    cycle();
    chk("flush_no_ghost", {31'b0, out_valid}, 32'd0);

    // patch a stalled entry
    in_valid = 1'b1; in_data = 32'h0000_0003; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0; patch_en = 1'b1;
    patch_mask = 32'hFFFF_0003; patch_data = 32'hBEEF_0000;
    cycle();
    chk("patch_data", out_data, 32'hBEEF_0000);
    chk("patch_valid", {31'b0, out_valid}, 32'd1);
    patch_en = 1'b0; out_ready = 1'b1;
    cycle();
    chk("patch_popped", {31'b0, out_valid}, 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid   = 1'($urandom_range(0, 1));
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      patch_en   = ($urandom_range(0, 7) == 0);
      in_data    = $urandom;
      patch_mask = $urandom;
      patch_data = $urandom;
      cycle();
    end

    // asynchronous reset mid-transfer
    in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0; patch_en = 1'b0; in_data = 32'h0BAD_0BAD;
    cycle();
    cycle();
    #2 nRST = 1'b0;
    #1;
    model_reset();
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_data", out_data, RV);
    in_valid = 1'b0;
    #2 nRST = 1'b1;
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
